// File: rtl/dw_addsub_simd_pkg.sv
// Shared encodings and helpers for the lane-partitioned add/sub pipeline.
package dw_addsub_simd_pkg;

  localparam logic [1:0] SEG_FULL = 2'b00;
  localparam logic [1:0] SEG_PAIR = 2'b01;
  localparam logic [1:0] SEG_LANE = 2'b10;

  localparam int MAX_LANES = 32;
  localparam int MAX_W     = 64;

  // One bit per lane, set where a segment ends (its most significant lane).
  function automatic logic [MAX_LANES-1:0] seg_top_mask(input logic [1:0] mode, input int lanes);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < lanes) begin
        case (mode)
          SEG_FULL: m[i] = (i == lanes - 1);
          SEG_PAIR: m[i] = ((i % 2) == 1);
          default:  m[i] = 1'b1;
        endcase
      end
    end
    return m;
  endfunction

  function automatic logic [MAX_W-1:0] sat_smax(input int n);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int k = 0; k < MAX_W; k++) begin
      if (k < n - 1) v[k] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [MAX_W-1:0] sat_smin(input int n);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int k = 0; k < MAX_W; k++) begin
      if (k == n - 1) v[k] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/dw_addsub_simd_pipe_if.sv
// Operand/result handshake bundle plus saturation status for dw_addsub_simd_pipe.
interface dw_addsub_simd_pipe_if #(
  parameter int LANE_W = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*LANE_W-1:0]   a;
  logic [LANES*LANE_W-1:0]   b;
  logic [LANES-1:0]          ci;
  logic [1:0]                seg_mode;
  logic                      addsub;
  logic                      tc;
  logic                      sat;
  logic                      avg;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*LANE_W-1:0]   sum;
  logic [LANES-1:0]          co;
  logic [LANES-1:0]          sat_flags;
  logic [CNT_W-1:0]          sat_cnt;
  logic                      clr_flags;

  modport master (
    output in_valid, a, b, ci, seg_mode, addsub, tc, sat, avg, out_ready, clr_flags,
    input  in_ready, out_valid, sum, co, sat_flags, sat_cnt
  );

  modport slave (
    input  in_valid, a, b, ci, seg_mode, addsub, tc, sat, avg, out_ready, clr_flags,
    output in_ready, out_valid, sum, co, sat_flags, sat_cnt
  );
endinterface

// File: rtl/dw_addsub_lane.sv
// One lane of the add/sub chain; carry-in comes from ci at a segment base, else from the lane below.
module dw_addsub_lane #(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              sub,
  input  logic              seg_start,
  input  logic              ci,
  input  logic              chain_in,
  output logic [LANE_W-1:0] s,
  output logic              cout
);
  logic [LANE_W-1:0] b_eff;
  logic              cin;

  // Subtract is a + ~b + ~borrow_in, so the chained carry is the inverted borrow.
  always_comb begin
    b_eff     = sub ? ~b : b;
    cin       = seg_start ? (ci ^ sub) : chain_in;
    {cout, s} = {1'b0, a} + {1'b0, b_eff} + {{LANE_W{1'b0}}, cin};
  end
endmodule

// File: rtl/dw_addsub_simd_pipe.sv
// Two-stage lane-partitioned add/sub with saturation, averaging and sticky saturation status.
module dw_addsub_simd_pipe
  import dw_addsub_simd_pkg::*;
#(
  parameter int LANE_W = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dw_addsub_simd_pipe_if.slave bus
);
  localparam int W = LANES * LANE_W;
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(sat_smax(LANE_W));
  localparam logic [LANE_W-1:0] LANE_MIN = LANE_W'(sat_smin(LANE_W));

  typedef struct packed {
    logic [W-1:0]     sum;
    logic [LANES-1:0] c;
    logic [LANES-1:0] ovf;
    logic [LANES-1:0] amsb;
    logic [LANES-1:0] top;
    logic             sub;
    logic             tc;
    logic             sat;
    logic             avg;
  } s1_t;

  logic [LANES-1:0] top_in, start_in, cout_in, chain;
  logic [LANES-1:0] c_seg, ovf_seg, amsb_seg;
  logic [W-1:0]     s_raw;

  s1_t              s1_d, s1_q;
  logic             s1_valid_d, s1_valid_q;
  logic             out_valid_d, out_valid_q;
  logic [W-1:0]     sum_d, sum_q, res_sum;
  logic [LANES-1:0] co_d, co_q, satseg_d, satseg_q, clamp_l;
  logic [LANES-1:0] sat_flags_d, sat_flags_q;
  logic [CNT_W-1:0] sat_cnt_d, sat_cnt_q, cnt_base;
  logic             s2_adv, in_ready, accept, out_hs;

  assign top_in   = LANES'(seg_top_mask(bus.seg_mode, LANES));
  assign start_in = {top_in[LANES-2:0], 1'b1};
  assign chain    = {cout_in[LANES-2:0], 1'b0};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dw_addsub_lane #(.LANE_W(LANE_W)) u_lane (
      .a         (bus.a[i*LANE_W +: LANE_W]),
      .b         (bus.b[i*LANE_W +: LANE_W]),
      .sub       (bus.addsub),
      .seg_start (start_in[i]),
      .ci        (bus.ci[i]),
      .chain_in  (chain[i]),
      .s         (s_raw[i*LANE_W +: LANE_W]),
      .cout      (cout_in[i])
    );
  end

  // Segment carry/borrow and overflow are only kept at the top lane of each segment.
  always_comb begin
    c_seg    = '0;
    ovf_seg  = '0;
    amsb_seg = '0;
    for (int i = 0; i < LANES; i++) begin
      c_seg[i]    = top_in[i] & (cout_in[i] ^ bus.addsub);
      ovf_seg[i]  = top_in[i] & (bus.a[i*LANE_W+LANE_W-1] == (bus.b[i*LANE_W+LANE_W-1] ^ bus.addsub))
                              & (s_raw[i*LANE_W+LANE_W-1] != bus.a[i*LANE_W+LANE_W-1]);
      amsb_seg[i] = top_in[i] & bus.a[i*LANE_W+LANE_W-1];
    end
  end

  always_comb begin
    logic             c_run, ovf_run, amsb_run;
    logic [LANE_W-1:0] cval;
    logic [W-1:0]     avg_sum;
    c_run    = 1'b0;
    ovf_run  = 1'b0;
    amsb_run = 1'b0;
    cval     = '0;
    clamp_l  = '0;
    res_sum  = s1_q.sum;
    avg_sum  = {1'b0, s1_q.sum[W-1:1]};
    // Walk down from the top so every lane sees the flags of the segment it belongs to.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (s1_q.top[i]) begin
        c_run    = s1_q.c[i];
        ovf_run  = s1_q.ovf[i];
        amsb_run = s1_q.amsb[i];
        avg_sum[i*LANE_W+LANE_W-1] = s1_q.tc ? (s1_q.sum[i*LANE_W+LANE_W-1] ^ s1_q.ovf[i]) : s1_q.c[i];
      end
      clamp_l[i] = s1_q.sat & ~s1_q.avg & (s1_q.tc ? ovf_run : c_run);
      if (!s1_q.tc)     cval = s1_q.sub ? '0 : '1;
      else if (amsb_run) cval = s1_q.top[i] ? LANE_MIN : '0;
      else               cval = s1_q.top[i] ? LANE_MAX : '1;
      if (clamp_l[i]) res_sum[i*LANE_W +: LANE_W] = cval;
    end
    if (s1_q.avg) res_sum = avg_sum;
  end

  assign s2_adv   = !out_valid_q || bus.out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = bus.in_valid && in_ready;
  assign out_hs   = out_valid_q && bus.out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    co_d        = co_q;
    satseg_d    = satseg_q;
    if (in_ready) s1_valid_d = bus.in_valid;
    if (accept) begin
      s1_d.sum  = s_raw;
      s1_d.c    = c_seg;
      s1_d.ovf  = ovf_seg;
      s1_d.amsb = amsb_seg;
      s1_d.top  = top_in;
      s1_d.sub  = bus.addsub;
      s1_d.tc   = bus.tc;
      s1_d.sat  = bus.sat;
      s1_d.avg  = bus.avg;
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d    = res_sum;
        co_d     = s1_q.c;
        satseg_d = s1_q.top & clamp_l;
      end
    end
    // A clear and a same-cycle event both take effect: clear first, then record.
    sat_flags_d = (bus.clr_flags ? '0 : sat_flags_q) | (out_hs ? satseg_q : '0);
    cnt_base    = bus.clr_flags ? '0 : sat_cnt_q;
    sat_cnt_d   = cnt_base;
    if (out_hs && (|satseg_q) && (cnt_base != '1)) sat_cnt_d = cnt_base + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      co_q        <= '0;
      satseg_q    <= '0;
      sat_flags_q <= '0;
      sat_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      co_q        <= co_d;
      satseg_q    <= satseg_d;
      sat_flags_q <= sat_flags_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.co        = co_q;
  assign bus.sat_flags = sat_flags_q;
  assign bus.sat_cnt   = sat_cnt_q;
endmodule
